// File: rtl/cmp_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmp_debounce : hysteretic debounced alarm from comparator gt/lt/et flags
// Revision 1.0
// ---------------------------------------------------------------------------
module cmp_debounce #(
  parameter int DW = 4,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld,
  input  logic          gt,
  input  logic          lt,
  input  logic          et,
  input  logic [DW-1:0] dbnc,
  output logic          alarm,
  output logic          alarm_rise,
  output logic          alarm_fall,
  output logic [EW-1:0] evt_cnt,
  output logic          err
);

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    PEND_HI = 2'd1,
    HIGH    = 2'd2,
    PEND_LO = 2'd3
  } state_t;

  localparam logic [DW-1:0] RUN_ONE = DW'(1);
  localparam logic [EW-1:0] EVT_ONE = EW'(1);

  state_t        state, state_nxt;
  logic [DW-1:0] run, run_nxt;
  logic          alarm_nxt, rise_nxt, fall_nxt, err_nxt;
  logic [EW-1:0] evt_nxt;

  logic          legal;
  logic [DW-1:0] len;
  logic          len_one;
  logic [DW:0]   run_inc;
  logic          done;

  assign legal   = vld && ({gt, lt, et} == 3'b100 || {gt, lt, et} == 3'b010 ||
                           {gt, lt, et} == 3'b001);
  assign len     = (dbnc == '0) ? RUN_ONE : dbnc;
  assign len_one = (len == RUN_ONE);
  assign run_inc = {1'b0, run} + {{DW{1'b0}}, 1'b1};
  // Greater-or-equal so that lowering dbnc mid-run completes the transition.
  assign done    = (run_inc >= {1'b0, len});

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    err_nxt   = err | (vld && !legal);
    if (legal) begin
      case (state)
        LOW: begin
          if (gt) begin
            if (len_one) begin
              state_nxt = HIGH;
            end else begin
              state_nxt = PEND_HI;
              run_nxt   = RUN_ONE;
            end
          end
        end
        PEND_HI: begin
          if (gt) begin
            if (done) begin
              state_nxt = HIGH;
              run_nxt   = '0;
            end else begin
              run_nxt   = run_inc[DW-1:0];
            end
          end else begin
            state_nxt = LOW;
            run_nxt   = '0;
          end
        end
        HIGH: begin
          if (lt) begin
            if (len_one) begin
              state_nxt = LOW;
            end else begin
              state_nxt = PEND_LO;
              run_nxt   = RUN_ONE;
            end
          end
        end
        PEND_LO: begin
          if (lt) begin
            if (done) begin
              state_nxt = LOW;
              run_nxt   = '0;
            end else begin
              run_nxt   = run_inc[DW-1:0];
            end
          end else begin
            state_nxt = HIGH;
            run_nxt   = '0;
          end
        end
        default: begin
          state_nxt = LOW;
          run_nxt   = '0;
        end
      endcase
    end
    alarm_nxt = (state_nxt == HIGH) || (state_nxt == PEND_LO);
    rise_nxt  = (state_nxt == HIGH) && ((state == LOW) || (state == PEND_HI));
    fall_nxt  = (state_nxt == LOW)  && ((state == HIGH) || (state == PEND_LO));
    evt_nxt   = evt_cnt;
    if (rise_nxt && (evt_cnt != '1)) begin
      evt_nxt = evt_cnt + EVT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOW;
      run        <= '0;
      alarm      <= 1'b0;
      alarm_rise <= 1'b0;
      alarm_fall <= 1'b0;
      evt_cnt    <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      run        <= run_nxt;
      alarm      <= alarm_nxt;
      alarm_rise <= rise_nxt;
      alarm_fall <= fall_nxt;
      evt_cnt    <= evt_nxt;
      err        <= err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmp_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmp_debounce : table-driven directed checks for cmp_debounce
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_cmp_debounce;

  logic       clk = 1'b0;
  logic       rst, vld, gt, lt, et;
  logic [3:0] dbnc;
  logic       alarm, alarm_rise, alarm_fall, err;
  logic [7:0] evt_cnt;
  logic       alarm2, rise2, fall2, err2;
  logic [1:0] evt_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cmp_debounce #(.DW(4), .EW(8)) u_dut (
    .clk(clk), .rst(rst), .vld(vld), .gt(gt), .lt(lt), .et(et), .dbnc(dbnc),
    .alarm(alarm), .alarm_rise(alarm_rise), .alarm_fall(alarm_fall),
    .evt_cnt(evt_cnt), .err(err)
  );

  // Narrow event counter instance, shares all inputs, exercises saturation.
  cmp_debounce #(.DW(4), .EW(2)) u_dut2 (
    .clk(clk), .rst(rst), .vld(vld), .gt(gt), .lt(lt), .et(et), .dbnc(dbnc),
    .alarm(alarm2), .alarm_rise(rise2), .alarm_fall(fall2),
    .evt_cnt(evt_cnt2), .err(err2)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [2:0] code;   // {gt, lt, et}
    logic [3:0] dbnc;
    logic       alarm;
    logic       rise;
    logic       fall;
    int         evt;
    logic       err;
  } vec_t;

  vec_t  vq[$];
  string nq[$];

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] L = 3'b010;
  localparam logic [2:0] E = 3'b001;
  localparam logic [2:0] N = 3'b000;

  function automatic void add(string nm, logic r, logic v, logic [2:0] c,
                              logic [3:0] d, logic a, logic ri, logic fa,
                              int ev, logic er);
    vec_t t;
    t.rst = r; t.vld = v; t.code = c; t.dbnc = d;
    t.alarm = a; t.rise = ri; t.fall = fa; t.evt = ev; t.err = er;
    vq.push_back(t);
    nq.push_back(nm);
  endfunction

  task automatic drive(logic r, logic v, logic [2:0] c, logic [3:0] d);
    @(negedge clk);
    rst = r; vld = v; {gt, lt, et} = c; dbnc = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic a, logic ri, logic fa, int ev, logic er);
    int ev2;
    ev2 = (ev > 3) ? 3 : ev;
    n_tests++;
    if (alarm !== a || alarm_rise !== ri || alarm_fall !== fa ||
        int'(evt_cnt) != ev || err !== er || int'(evt_cnt2) != ev2 ||
        alarm2 !== a || (alarm_rise && alarm_fall)) begin
      n_fail++;
      $display("FAIL %s: got alarm=%0b rise=%0b fall=%0b evt=%0d evt2=%0d err=%0b, want alarm=%0b rise=%0b fall=%0b evt=%0d evt2=%0d err=%0b",
               nm, alarm, alarm_rise, alarm_fall, evt_cnt, evt_cnt2, err,
               a, ri, fa, ev, ev2, er);
    end
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; gt = 1'b0; lt = 1'b0; et = 1'b0; dbnc = 4'd0;

    //   name          rst vld code dbnc  alarm rise fall evt err
    add("reset",        1, 0, N, 3,    0, 0, 0, 0, 0);
    add("rise_g1",      0, 1, G, 3,    0, 0, 0, 0, 0);
    add("rise_g2",      0, 1, G, 3,    0, 0, 0, 0, 0);
    add("rise_g3",      0, 1, G, 3,    1, 1, 0, 1, 0);
    add("novld_junk",   0, 0, 3'b110, 3, 1, 0, 0, 1, 0);
    add("rst2",         1, 0, N, 3,    0, 0, 0, 0, 0);
    add("brk_g1",       0, 1, G, 3,    0, 0, 0, 0, 0);
    add("brk_g2",       0, 1, G, 3,    0, 0, 0, 0, 0);
    add("brk_e",        0, 1, E, 3,    0, 0, 0, 0, 0);
    add("brk_g4",       0, 1, G, 3,    0, 0, 0, 0, 0);
    add("brk_g5",       0, 1, G, 3,    0, 0, 0, 0, 0);
    add("brk_g6",       0, 1, G, 3,    1, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) add("hyst_e", 0, 1, E, 3, 1, 0, 0, 1, 0);
    add("fall_l1",      0, 1, L, 2,    1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add("fall_gap", 0, 0, N, 2, 1, 0, 0, 1, 0);
    add("fall_l2",      0, 1, L, 2,    0, 0, 1, 1, 0);
    add("fall_after",   0, 0, N, 2,    0, 0, 0, 1, 0);
    add("ill_g1",       0, 1, G, 3,    0, 0, 0, 1, 0);
    add("ill_code",     0, 1, 3'b110, 3, 0, 0, 0, 1, 1);
    add("ill_g2",       0, 1, G, 3,    0, 0, 0, 1, 1);
    add("ill_g3",       0, 1, G, 3,    1, 1, 0, 2, 1);
    add("lower_l1",     0, 1, L, 4,    1, 0, 0, 2, 1);
    add("lower_l2",     0, 1, L, 4,    1, 0, 0, 2, 1);
    add("lower_l3",     0, 1, L, 2,    0, 0, 1, 2, 1);
    add("rst3",         1, 0, N, 4,    0, 0, 0, 0, 0);
    add("mid_g1",       0, 1, G, 4,    0, 0, 0, 0, 0);
    add("mid_g2",       0, 1, G, 4,    0, 0, 0, 0, 0);
    add("mid_g3",       0, 1, G, 4,    0, 0, 0, 0, 0);
    add("mid_rst_g",    1, 1, G, 4,    0, 0, 0, 0, 0);
    add("fresh_g1",     0, 1, G, 4,    0, 0, 0, 0, 0);
    add("fresh_g2",     0, 1, G, 4,    0, 0, 0, 0, 0);
    add("fresh_g3",     0, 1, G, 4,    0, 0, 0, 0, 0);
    add("fresh_g4",     0, 1, G, 4,    1, 1, 0, 1, 0);
    add("rst4",         1, 0, N, 0,    0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      add("d0_gt",      0, 1, G, 0,    1, 1, 0, i + 1, 0);
      add("d0_lt",      0, 1, L, 0,    0, 0, 1, i + 1, 0);
    end

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].vld, vq[i].code, vq[i].dbnc);
      check(nq[i], vq[i].alarm, vq[i].rise, vq[i].fall, vq[i].evt, vq[i].err);
    end

    // Sticky err from an all-zero code, held across idle cycles until reset.
    drive(1'b1, 1'b0, N, 4'd2);
    check("seq_rst", 0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, N, 4'd2);
    check("seq_err000", 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, N, 4'd2);
    check("seq_err_hold", 0, 0, 0, 0, 1);
    drive(1'b0, 1'b1, 3'b111, 4'd1);
    check("seq_err111_ignored", 0, 0, 0, 0, 1);
    drive(1'b0, 1'b1, G, 4'd1);
    check("seq_l1_rise", 1, 1, 0, 1, 1);
    drive(1'b1, 1'b0, N, 4'd1);
    check("seq_err_clr", 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
